axi_ar_push: RTL
================

Name: axi_ar_push

Overview:
- Write side of the AXI slave read-request path.
- Accepts AR-channel handshakes from the AXI master and checks each burst for legality.
- Replaces the master ARID with an internal tag, packs legal requests and pushes them into the AR FIFO.
- Keeps a tag→ARID table for the R response path and diverts illegal bursts to an error-response request (no FIFO push).

Parameters:
- ARFIFO_DEPTH, 8, AR FIFO depth; also the number of tags; TAG_W = $clog2(ARFIFO_DEPTH).
- ID_WIDTH, 4, width of the master ARID.
- ADDR_WIDTH, 64, address width.
- ARUSER_WIDTH, 3, ARUSER width.
- DATA_WIDTH, 128, AXI data bus width; MAX_SIZE = $clog2(DATA_WIDTH/8).
- ENTRY_W, TAG_W+ADDR_WIDTH+8+3+2+ARUSER_WIDTH, FIFO entry width (derived).

Ports:
- clk  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- ARVALID  in  1  AR valid.
- ARREADY  out  1  AR ready.
- ARID  in  ID_WIDTH  master ID.
- ARADDR  in  ADDR_WIDTH  start address.
- ARLEN  in  8  beats-1.
- ARSIZE  in  3  bytes/beat log2.
- ARBURST  in  2  burst type.
- ARUSER  in  ARUSER_WIDTH  user field.
- fifo_wr_en  out  1  AR FIFO push strobe.
- fifo_wr_data  out  ENTRY_W  packed entry: {tag, addr, len, size, burst, user}, MSB first.
- fifo_full  in  1  AR FIFO full.
- tag_lkp_idx  in  TAG_W  lookup index from the response path.
- tag_lkp_id  out  ID_WIDTH  combinational ARID for tag_lkp_idx.
- tag_release  in  1  one-cycle pulse: oldest outstanding tag retired (in-order).
- err_valid  out  1  error response request.
- err_id  out  ID_WIDTH  ARID of the rejected burst.
- err_len  out  8  ARLEN of the rejected burst (beats to return as SLVERR).
- err_ready  in  1  error request accepted.

Behaviour:
- The clk, single-clock-domain design uses an asynchronous, active-high reset (ARESET).
- Reset values: ARREADY=0, fifo_wr_en=0, fifo_wr_data=0, err_valid=0, err_id=0, err_len=0, wr_tag=0, outstanding=0, state=IDLE. The tag table is cleared to 0.
- ARESET asserted mid-operation aborts any held entry or error immediately; nothing is pushed afterwards.
- State IDLE:
  - ARREADY = !fifo_full && (outstanding < ARFIFO_DEPTH).
  - On ARVALID&&ARREADY: capture all AR fields into a holding register and evaluate legality.
  - Legal → PUSH; illegal → ERR.
- Illegal when any of the following holds:
  - ARBURST==2'b11.
  - ARSIZE > MAX_SIZE.
  - ARBURST==WRAP and ARLEN not in {1,3,7,15}.
  - 4KB crossing (see Optional Feature).
- State PUSH:
  - ARREADY=0.
  - When !fifo_full: fifo_wr_en=1 for exactly one cycle with fifo_wr_data = {wr_tag, addr, len, size, burst, user}.
  - In the same edge: table[wr_tag] <= ARID, wr_tag <= wr_tag+1 mod ARFIFO_DEPTH, outstanding+1; state → IDLE.
  - If fifo_full: hold with fifo_wr_en=0.
- State ERR:
  - err_valid=1, with err_id and err_len held stable until err_ready. On err_ready: → IDLE.
  - No tag is consumed, and no FIFO push occurs.
- One-cycle gap: ARREADY is never asserted in the cycle a push or error completes, so back-to-back requests are at best 2 cycles apart.
- tag_release:
  - Decrements outstanding.
  - Simultaneous push and release: outstanding unchanged.
  - Release with outstanding==0: ignored (no underflow).
- wr_tag wraps from ARFIFO_DEPTH-1 to 0.
- outstanding saturates at ARFIFO_DEPTH; ARREADY is held low while full.
- The ARID→tag table is written only on a push. tag_lkp_id is a combinational read.

Optional Feature:
- Macro: AR_4KB_CHECK_EN.
- Defined: for INCR bursts, compute aligned = ARADDR[11:0] & ~((1<<ARSIZE)-1) in 13 bits.
  - Burst is illegal if aligned + ((ARLEN+1)<<ARSIZE) > 4096, computed in 21-bit arithmetic.
  - FIXED and WRAP bursts are exempt.
- Not defined: no 4KB check; INCR legality depends only on ARSIZE.

Test Plan:
- Reset then single INCR read (ARID=3, ARADDR=0x1000, ARLEN=3, ARSIZE=4): ARREADY=1 in IDLE; fifo_wr_en pulses on the 2nd cycle after handshake with tag=0; tag_lkp_idx=0 → tag_lkp_id=3.
- 8 legal requests, no tag_release: tags 0..7 pushed; outstanding=8; ARREADY stays 0. One tag_release → ARREADY=1; next push uses tag 0 (wrap).
- ARBURST=2'b11, ARID=5, ARLEN=7: no fifo_wr_en; err_valid=1, err_id=5, err_len=7. Hold err_ready=0 for 3 cycles: outputs stable. err_ready=1 → back to IDLE; outstanding unchanged.
- With AR_4KB_CHECK_EN, ARADDR=0xFF0, ARSIZE=4, ARLEN=1 (crosses) → ERR.
  - Same request without the macro → pushed.
  - ARADDR=0xFE0, ARLEN=1 → pushed in both builds.
- fifo_full=1 asserted while in PUSH for 4 cycles: fifo_wr_en=0 throughout; exactly one push on the first cycle after fifo_full drops.
- ARESET pulse while in PUSH with fifo_full=1: all outputs return to reset values and the held entry is never pushed. Simultaneous push and tag_release at outstanding=2 → outstanding stays 2.

Source files
------------

// File: rtl/axi_ar_push.sv
// axi_ar_push: accepts AR handshakes, screens each burst for legality, swaps ARID for an
// internal tag and pushes legal requests into the AR FIFO. Define AR_4KB_CHECK_EN to reject INCR 4KB crossings.
//
// state | meaning
// IDLE  | ready for a new AR handshake
// PUSH  | legal request held, waiting for room in the AR FIFO
// ERR   | illegal request held, error response request presented
module axi_ar_push #(
  parameter int ARFIFO_DEPTH = 8,
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int ARUSER_WIDTH = 3,
  parameter int DATA_WIDTH   = 128,
  localparam int TAG_W       = $clog2(ARFIFO_DEPTH),
  localparam int ENTRY_W     = TAG_W + ADDR_WIDTH + 8 + 3 + 2 + ARUSER_WIDTH
) (
  input  logic                    clk,
  input  logic                    ARESET,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [ARUSER_WIDTH-1:0] ARUSER,
  output logic                    fifo_wr_en,
  output logic [ENTRY_W-1:0]      fifo_wr_data,
  input  logic                    fifo_full,
  input  logic [TAG_W-1:0]        tag_lkp_idx,
  output logic [ID_WIDTH-1:0]     tag_lkp_id,
  input  logic                    tag_release,
  output logic                    err_valid,
  output logic [ID_WIDTH-1:0]     err_id,
  output logic [7:0]              err_len,
  input  logic                    err_ready
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W + 1)'(ARFIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, ERR} state_t;

  state_t state, state_nxt;

  logic                    hs, push, rel, illegal, wrap_len_ok, cross_4k;
  logic [TAG_W:0]          outstanding;
  logic [TAG_W-1:0]        wr_tag;
  logic [ID_WIDTH-1:0]     h_id;
  logic [ADDR_WIDTH-1:0]   h_addr;
  logic [7:0]              h_len;
  logic [2:0]              h_size;
  logic [1:0]              h_burst;
  logic [ARUSER_WIDTH-1:0] h_user;
  logic [ID_WIDTH-1:0]     tag_tbl [ARFIFO_DEPTH];

`ifdef AR_4KB_CHECK_EN
  logic [12:0] aligned;
  logic [20:0] span;

  always_comb begin
    aligned  = {1'b0, ARADDR[11:0]} & ~((13'd1 << ARSIZE) - 13'd1);
    span     = (21'(ARLEN) + 21'd1) << ARSIZE;
    cross_4k = (ARBURST == 2'b01) && ((21'(aligned) + span) > 21'd4096);
  end
`else
  assign cross_4k = 1'b0;
`endif

  assign wrap_len_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
  assign illegal = (ARBURST == 2'b11) || (ARSIZE > MAX_SIZE_L) ||
                   ((ARBURST == 2'b10) && !wrap_len_ok) || cross_4k;

  // a release with nothing outstanding is dropped so the count cannot underflow
  assign rel = tag_release && (outstanding != '0);

  assign tag_lkp_id = tag_tbl[tag_lkp_idx];

  always_ff @(posedge clk or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ARREADY   = 1'b0;
    err_valid = 1'b0;
    push      = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        // gated by ARESET so ARREADY reads low while reset is held
        ARREADY = !ARESET && !fifo_full && (outstanding < DEPTH_C);
        hs      = ARVALID && ARREADY;
        if (hs) state_nxt = illegal ? ERR : PUSH;
      end
      PUSH: begin
        push = !fifo_full;
        if (push) state_nxt = IDLE;
      end
      ERR: begin
        err_valid = 1'b1;
        if (err_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ARESET) begin
    if (ARESET) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      err_id       <= '0;
      err_len      <= '0;
      wr_tag       <= '0;
      outstanding  <= '0;
      h_id         <= '0;
      h_addr       <= '0;
      h_len        <= '0;
      h_size       <= '0;
      h_burst      <= '0;
      h_user       <= '0;
      for (int i = 0; i < ARFIFO_DEPTH; i++) tag_tbl[i] <= '0;
    end else begin
      fifo_wr_en <= push;
      if (hs) begin
        h_id    <= ARID;
        h_addr  <= ARADDR;
        h_len   <= ARLEN;
        h_size  <= ARSIZE;
        h_burst <= ARBURST;
        h_user  <= ARUSER;
        if (illegal) begin
          err_id  <= ARID;
          err_len <= ARLEN;
        end
      end
      if (push) begin
        fifo_wr_data    <= {wr_tag, h_addr, h_len, h_size, h_burst, h_user};
        tag_tbl[wr_tag] <= h_id;
        wr_tag          <= (wr_tag == TAG_W'(ARFIFO_DEPTH - 1)) ? '0 : wr_tag + TAG_W'(1);
      end
      case ({push, rel})
        2'b10:   if (outstanding < DEPTH_C) outstanding <= outstanding + (TAG_W + 1)'(1);
        2'b01:   outstanding <= outstanding - (TAG_W + 1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
